// File: rtl/xor_cipher_pkg.sv
// Shared types and default sizes for the XOR stream cipher controller.
// Imported by the controller top and its serializer.
package xor_cipher_pkg;

  localparam int M_DEF   = 32;
  localparam int W_DEF   = 8;
  localparam int LAT_DEF = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CFG   = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef enum logic {
    LANE_TX = 1'b0,
    LANE_RX = 1'b1
  } lane_t;

endpackage

// File: rtl/xor_cipher_ser.sv
// Shared word serializer/deserializer: drives a word out LSB first and
// rebuilds the returning bit stream into a word, also LSB first.
module xor_cipher_ser
  import xor_cipher_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         i_load,
  input  logic [W-1:0] i_word,
  input  logic         i_shift,
  output logic         o_bit,
  input  logic         i_sample,
  input  logic         i_bit,
  output logic [W-1:0] o_word_next
);

  logic [W-1:0] r_sreg;
  logic [W-1:0] r_acc;

  // r_sreg holds only the bits not yet driven; bit 0 is launched directly at load.
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_sreg <= i_word >> 1;
    end else if (i_shift) begin
      r_sreg <= r_sreg >> 1;
    end
    if (i_sample) begin
      r_acc <= o_word_next;
    end
  end

  assign o_bit       = r_sreg[0];
  assign o_word_next = {i_bit, r_acc[W-1:1]};

endmodule

// File: rtl/xor_cipher_ctrl.sv
// Key loader, round-robin lane arbiter and bit-serial sequencer that
// time-shares one dual-lane XOR stream cipher between TX and RX byte requests.
module xor_cipher_ctrl
  import xor_cipher_pkg::*;
#(
  parameter int M   = M_DEF,
  parameter int W   = W_DEF,
  parameter int LAT = LAT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [M-1:0] key_data,
  output logic         key_ready,
  output logic [M-1:0] key_echo,
  output logic         key_loaded,
  input  logic         tx_valid,
  output logic         tx_ready,
  input  logic [W-1:0] tx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  input  logic [W-1:0] rx_data,
  output logic         tx_out_valid,
  output logic [W-1:0] tx_out_data,
  output logic         rx_out_valid,
  output logic [W-1:0] rx_out_data,
  output logic         cfg_en,
  output logic         cfg_i,
  input  logic         cfg_o,
  output logic         tx_en,
  output logic         tx_p,
  input  logic         tx_e,
  output logic         rx_en,
  output logic         rx_e,
  input  logic         rx_p
);

  localparam int CNT_W = $clog2(M + W + LAT + 1);

  state_t           r_state;
  lane_t            r_lane;
  lane_t            r_rr;
  logic [CNT_W-1:0] r_cnt;
  logic [M-1:0]     r_key;
  logic [M-1:0]     r_key_echo;
  logic             r_key_loaded;
  logic             r_cfg_en, r_cfg_i;
  logic             r_tx_en, r_tx_p, r_rx_en, r_rx_e;
  logic             r_tx_out_valid, r_rx_out_valid;
  logic [W-1:0]     r_tx_out_data, r_rx_out_data;
  logic [LAT-1:0]   r_en_d;

  logic         w_idle, w_data_ok, w_grant_tx, w_grant_rx, w_load;
  logic         w_ser_bit, w_lane_bit;
  logic [W-1:0] w_sel_data, w_word_next;

  assign w_idle     = (r_state == IDLE);
  assign w_data_ok  = w_idle & r_key_loaded & ~key_valid;
  assign w_grant_tx = tx_valid & (~rx_valid | (r_rr == LANE_TX));
  assign w_grant_rx = rx_valid & ~w_grant_tx;
  assign w_load     = w_data_ok & (w_grant_tx | w_grant_rx);
  assign w_sel_data = w_grant_tx ? tx_data : rx_data;
  assign w_lane_bit = (r_lane == LANE_TX) ? tx_e : rx_p;

  assign key_ready    = w_idle;
  assign tx_ready     = w_data_ok & w_grant_tx;
  assign rx_ready     = w_data_ok & w_grant_rx;
  assign key_echo     = r_key_echo;
  assign key_loaded   = r_key_loaded;
  assign cfg_en       = r_cfg_en;
  assign cfg_i        = r_cfg_i;
  assign tx_en        = r_tx_en;
  assign tx_p         = r_tx_p;
  assign rx_en        = r_rx_en;
  assign rx_e         = r_rx_e;
  assign tx_out_valid = r_tx_out_valid;
  assign tx_out_data  = r_tx_out_data;
  assign rx_out_valid = r_rx_out_valid;
  assign rx_out_data  = r_rx_out_data;

  xor_cipher_ser #(.W(W)) u_ser (
    .clk         (clk),
    .i_load      (w_load),
    .i_word      (w_sel_data),
    .i_shift     (r_state == SHIFT),
    .o_bit       (w_ser_bit),
    .i_sample    (r_en_d[LAT-1]),
    .i_bit       (w_lane_bit),
    .o_word_next (w_word_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_lane         <= LANE_TX;
      r_rr           <= LANE_TX;
      r_cnt          <= '0;
      r_key          <= '0;
      r_key_echo     <= '0;
      r_key_loaded   <= 1'b0;
      r_cfg_en       <= 1'b0;
      r_cfg_i        <= 1'b0;
      r_tx_en        <= 1'b0;
      r_tx_p         <= 1'b0;
      r_rx_en        <= 1'b0;
      r_rx_e         <= 1'b0;
      r_tx_out_valid <= 1'b0;
      r_rx_out_valid <= 1'b0;
      r_tx_out_data  <= '0;
      r_rx_out_data  <= '0;
      r_en_d         <= '0;
    end else begin
      // Enable delayed by the cipher latency marks the cycles whose output bit is live.
      r_en_d[0] <= r_tx_en | r_rx_en;
      for (int i = 1; i < LAT; i++) begin
        r_en_d[i] <= r_en_d[i-1];
      end
      r_tx_out_valid <= 1'b0;
      r_rx_out_valid <= 1'b0;

      case (r_state)
        IDLE: begin
          if (key_valid) begin
            r_key    <= key_data << 1;
            r_cfg_en <= 1'b1;
            r_cfg_i  <= key_data[M-1];
            r_cnt    <= '0;
            r_state  <= CFG;
          end else if (w_load) begin
            r_lane  <= w_grant_tx ? LANE_TX : LANE_RX;
            r_rr    <= w_grant_tx ? LANE_RX : LANE_TX;
            r_tx_en <= w_grant_tx;
            r_tx_p  <= w_grant_tx & tx_data[0];
            r_rx_en <= w_grant_rx;
            r_rx_e  <= w_grant_rx & rx_data[0];
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        CFG: begin
          r_key_echo <= {r_key_echo[M-2:0], cfg_o};
          if (r_cnt == CNT_W'(M - 1)) begin
            r_cfg_en     <= 1'b0;
            r_cfg_i      <= 1'b0;
            r_key_loaded <= 1'b1;
            r_cnt        <= '0;
            r_state      <= IDLE;
          end else begin
            r_cfg_i <= r_key[M-1];
            r_key   <= r_key << 1;
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (r_cnt == CNT_W'(W - 1)) begin
            r_tx_en <= 1'b0;
            r_tx_p  <= 1'b0;
            r_rx_en <= 1'b0;
            r_rx_e  <= 1'b0;
            r_cnt   <= '0;
            r_state <= DRAIN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_lane == LANE_TX) begin
              r_tx_p <= w_ser_bit;
            end else begin
              r_rx_e <= w_ser_bit;
            end
          end
        end
        DRAIN: begin
          // The last output bit is captured on this same edge, so publish the next-value word.
          if (r_cnt == CNT_W'(LAT - 1)) begin
            r_cnt <= '0;
            if (r_lane == LANE_TX) begin
              r_tx_out_valid <= 1'b1;
              r_tx_out_data  <= w_word_next;
            end else begin
              r_rx_out_valid <= 1'b1;
              r_rx_out_data  <= w_word_next;
            end
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xor_cipher_ctrl.sv
// Randomized bench for xor_cipher_ctrl against a behavioural cipher core and
// a word-level keystream reference model.
module tb_xor_cipher_ctrl;
  localparam int M   = 32;
  localparam int W   = 8;
  localparam int LAT = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_valid, key_ready, key_loaded;
  logic [M-1:0] key_data, key_echo;
  logic         tx_valid, tx_ready, rx_valid, rx_ready;
  logic [W-1:0] tx_data, rx_data;
  logic         tx_out_valid, rx_out_valid;
  logic [W-1:0] tx_out_data, rx_out_data;
  logic         cfg_en, cfg_i, cfg_o;
  logic         tx_en, tx_p, tx_e, rx_en, rx_e, rx_p;

  xor_cipher_ctrl #(.M(M), .W(W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .key_valid(key_valid), .key_data(key_data), .key_ready(key_ready),
    .key_echo(key_echo), .key_loaded(key_loaded),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .tx_out_valid(tx_out_valid), .tx_out_data(tx_out_data),
    .rx_out_valid(rx_out_valid), .rx_out_data(rx_out_data),
    .cfg_en(cfg_en), .cfg_i(cfg_i), .cfg_o(cfg_o),
    .tx_en(tx_en), .tx_p(tx_p), .tx_e(tx_e),
    .rx_en(rx_en), .rx_e(rx_e), .rx_p(rx_p)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural cipher core: serial key register, one keystream position per lane bit.
  logic [M-1:0] cph_key;
  int           cph_tidx, cph_ridx;
  assign cfg_o = cph_key[M-1];
  always @(posedge clk) begin
    if (rst) begin
      cph_key  <= '0;
      cph_tidx <= 0;
      cph_ridx <= 0;
      tx_e     <= 1'b0;
      rx_p     <= 1'b0;
    end else begin
      if (cfg_en) cph_key <= {cph_key[M-2:0], cfg_i};
      if (tx_en) begin
        tx_e     <= tx_p ^ cph_key[cph_tidx];
        cph_tidx <= (cph_tidx + 1) % M;
      end
      if (rx_en) begin
        rx_p     <= rx_e ^ cph_key[cph_ridx];
        cph_ridx <= (cph_ridx + 1) % M;
      end
    end
  end

  // Reference model state
  logic [M-1:0] m_key;
  int           m_tx_n, m_rx_n;
  bit           m_rr;

  function automatic logic [W-1:0] ks(input logic [M-1:0] key, input int n);
    logic [W-1:0] b;
    for (int k = 0; k < W; k++) b[k] = key[(n * W + k) % M];
    return b;
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return {7'd0, key_echo, key_loaded, tx_out_valid, tx_out_data, rx_out_valid,
            rx_out_data, cfg_en, cfg_i, tx_en, tx_p, rx_en, rx_e};
  endfunction

  task automatic model_reset();
    m_key  = '0;
    m_tx_n = 0;
    m_rx_n = 0;
    m_rr   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic load_key(input logic [M-1:0] k);
    logic [M-1:0] bits;
    int           n_en;
    key_valid = 1'b1;
    key_data  = k;
    #1;
    chk_eq("key_ready_idle", key_ready, 1);
    tick();
    key_valid = 1'b0;
    key_data  = $urandom();
    n_en = 0;
    bits = '0;
    for (int c = 1; c <= M; c++) begin
      if (cfg_en) begin
        n_en++;
        bits = {bits[M-2:0], cfg_i};
      end
      tick();
    end
    chk_eq("cfg_en_cycles", n_en, M);
    chk_eq("cfg_i_bits", bits, k);
    chk_eq("cfg_en_off", cfg_en, 0);
    chk_eq("key_loaded", key_loaded, 1);
    chk_eq("key_ready_back", key_ready, 1);
    chk_eq("key_echo", key_echo, m_key);
    m_key = k;
  endtask

  task automatic send(input bit lane, input logic [W-1:0] d, output logic [W-1:0] got);
    logic [W-1:0] bits, exp;
    int           n_en, n_pulse, pulse_c, n_other;
    if (lane) begin rx_valid = 1'b1; rx_data = d; end
    else      begin tx_valid = 1'b1; tx_data = d; end
    #1;
    chk_eq(lane ? "rx_ready" : "tx_ready", lane ? rx_ready : tx_ready, 1);
    exp = d ^ ks(m_key, lane ? m_rx_n : m_tx_n);
    tick();
    tx_valid = 1'b0;
    rx_valid = 1'b0;
    tx_data  = $urandom();
    rx_data  = $urandom();
    n_en = 0; n_pulse = 0; pulse_c = -1; n_other = 0; bits = '0; got = '0;
    for (int c = 1; c <= W + 3; c++) begin
      if (lane ? rx_en : tx_en) begin
        n_en++;
        bits = {(lane ? rx_e : tx_p), bits[W-1:1]};
      end
      if (lane ? (tx_en | tx_p | tx_out_valid) : (rx_en | rx_e | rx_out_valid)) n_other++;
      if (cfg_en) n_other++;
      if (lane ? rx_out_valid : tx_out_valid) begin
        n_pulse++;
        pulse_c = c;
        got = lane ? rx_out_data : tx_out_data;
      end
      if (c < W + 3) tick();
    end
    chk_eq("lane_en_cycles", n_en, W);
    chk_eq("lane_bits", bits, d);
    chk_eq("other_lane_quiet", n_other, 0);
    chk_eq("out_pulse_count", n_pulse, 1);
    chk_eq("out_pulse_cycle", pulse_c, W + 2);
    chk_eq(lane ? "rx_out_data" : "tx_out_data", got, exp);
    chk_eq("out_data_hold", lane ? rx_out_data : tx_out_data, exp);
    chk_eq("ready_again", key_ready, 1);
    if (lane) m_rx_n++; else m_tx_n++;
    m_rr = ~lane;
  endtask

  task automatic mon_outs(inout logic [W-1:0] q_tx[$], inout logic [W-1:0] q_rx[$]);
    if (tx_out_valid) begin
      if (q_tx.size() > 0) chk_eq("stream_tx_out", tx_out_data, q_tx.pop_front());
      else chk_eq("stream_tx_unexpected", tx_out_valid, 0);
    end
    if (rx_out_valid) begin
      if (q_rx.size() > 0) chk_eq("stream_rx_out", rx_out_data, q_rx.pop_front());
      else chk_eq("stream_rx_unexpected", rx_out_valid, 0);
    end
  endtask

  // Both data lanes held valid; grants must alternate per the round-robin pointer.
  task automatic stream(input int n, output int first_cyc);
    logic [W-1:0] q_tx[$], q_rx[$];
    int g, last, budget;
    bit pend_tx, pend_rx;
    g = 0; last = -1; first_cyc = -1; pend_tx = 0; pend_rx = 0;
    budget = n * (W + 3) + 2 * M + 20;
    tx_valid = 1'b1;
    rx_valid = 1'b1;
    while (g < n && budget > 0) begin
      budget--;
      mon_outs(q_tx, q_rx);
      #1;
      if (tx_ready || rx_ready) begin
        chk_eq("grant_lane", rx_ready, m_rr);
        if (last >= 0) chk_eq("grant_gap", cyc - last, W + 3);
        else first_cyc = cyc;
        last = cyc;
        if (rx_ready) begin
          q_rx.push_back(rx_data ^ ks(m_key, m_rx_n));
          m_rx_n++; m_rr = 1'b0; pend_rx = 1;
        end else begin
          q_tx.push_back(tx_data ^ ks(m_key, m_tx_n));
          m_tx_n++; m_rr = 1'b1; pend_tx = 1;
        end
        g++;
      end
      tick();
      if (pend_tx) begin tx_data = $urandom(); pend_tx = 0; end
      if (pend_rx) begin rx_data = $urandom(); pend_rx = 0; end
    end
    tx_valid = 1'b0;
    rx_valid = 1'b0;
    chk_eq("stream_grants", g, n);
    for (int c = 0; c < W + 4; c++) begin
      mon_outs(q_tx, q_rx);
      tick();
    end
    chk_eq("stream_q_empty", q_tx.size() + q_rx.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ct, pt, r;
    logic [M-1:0] old_key, new_key;
    int acc, t_key, first, n_out, n_rdy;

    rst = 1'b1; key_valid = 0; key_data = '0; tx_valid = 0; rx_valid = 0;
    tx_data = '0; rx_data = '0;
    tick();
    do_reset();
    chk_eq("reset_outs_zero", all_outs(), 0);
    chk_eq("reset_key_ready", key_ready, 1);

    // Data without a key is held off indefinitely.
    tx_valid = 1'b1; rx_valid = 1'b1; tx_data = $urandom(); rx_data = $urandom();
    acc = 0;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (tx_ready | rx_ready | cfg_en | cfg_i | tx_en | tx_p | rx_en | rx_e) acc++;
      tick();
    end
    chk_eq("nokey_hold", acc, 0);
    tx_valid = 1'b0; rx_valid = 1'b0;

    load_key(32'hA5A5_0F0F);
    load_key(32'h1234_5678);
    chk_eq("key_echo_prev", key_echo, 32'hA5A5_0F0F);

    send(1'b0, 8'h3C, ct);
    send(1'b1, ct, pt);
    chk_eq("rx_roundtrip", pt, 8'h3C);

    load_key($urandom());
    for (int i = 0; i < 8; i++) send(1'($urandom_range(0, 1)), 8'($urandom()), r);

    send(1'b1, 8'($urandom()), r);
    stream(6, first);

    // Key, TX and RX requested together: key first, then TX, then RX.
    send(1'b1, 8'($urandom()), r);
    old_key = m_key;
    new_key = $urandom();
    key_valid = 1'b1; key_data = new_key; tx_valid = 1'b1; rx_valid = 1'b1;
    tx_data = $urandom(); rx_data = $urandom();
    #1;
    chk_eq("combo_key_ready", key_ready, 1);
    chk_eq("combo_data_held", {tx_ready, rx_ready}, 0);
    t_key = cyc;
    tick();
    key_valid = 1'b0;
    m_key = new_key;
    stream(2, first);
    chk_eq("combo_first_grant", first - t_key, M + 1);
    chk_eq("combo_key_echo", key_echo, old_key);

    // Reset in the middle of SHIFT discards the word.
    tx_valid = 1'b1; tx_data = $urandom();
    #1;
    chk_eq("rst_pre_tx_ready", tx_ready, 1);
    tick();
    tx_valid = 1'b0;
    tick(); tick(); tick();
    chk_eq("rst_shift_c4", tx_en, 1);
    rst = 1'b1; tx_valid = 1'b1;
    tick();
    chk_eq("rst_outs_zero", all_outs(), 0);
    chk_eq("rst_key_loaded", key_loaded, 0);
    chk_eq("rst_tx_ready", tx_ready, 0);
    rst = 1'b0;
    model_reset();
    n_out = 0; n_rdy = 0;
    for (int c = 0; c < W + 4; c++) begin
      if (tx_out_valid | rx_out_valid) n_out++;
      if (tx_ready) n_rdy++;
      tick();
    end
    chk_eq("rst_no_out_valid", n_out, 0);
    chk_eq("rst_no_ready", n_rdy, 0);
    tx_valid = 1'b0;

    load_key($urandom());
    send(1'b0, 8'($urandom()), r);
    send(1'b1, 8'($urandom()), r);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/xor_cipher_ctrl.md
# xor_cipher_ctrl

Controller that configures and time-shares one bit-serial dual XOR stream cipher instance (M-bit key, separate TX-encrypt and RX-decrypt lanes). It loads the key through the cipher's serial config port and accepts byte-wide TX plaintext and RX ciphertext requests. It grants the cipher to one requester at a time with round-robin, serializes the byte into the cipher, and reassembles the cipher's output byte. It sits between the tile's byte-level host logic and the cipher core.

## Interface
- M, 32: key length in bits; must equal the cipher's M.
- W, 8: data word width per request.
- LAT, 1: cipher pipeline latency in cycles from tx_p/rx_e to tx_e/rx_p.
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high; same net drives the cipher's rst.
- key_valid  in  1  new key offered.
- key_data  in  M  key value.
- key_ready  out  1  key accepted when key_valid & key_ready.
- key_echo  out  M  previous key shifted out of cfg_o during the last load.
- key_loaded  out  1  a key has been loaded since reset.
- tx_valid / tx_ready  in/out  1  TX plaintext handshake.
- tx_data  in  W  plaintext byte.
- rx_valid / rx_ready  in/out  1  RX ciphertext handshake.
- rx_data  in  W  ciphertext byte.
- tx_out_valid  out  1  one-cycle pulse; tx_out_data is valid.
- tx_out_data  out  W  encrypted byte.
- rx_out_valid  out  1  one-cycle pulse; rx_out_data is valid.
- rx_out_data  out  W  decrypted byte.
- cfg_en, cfg_i  out  1  cipher config port.
- cfg_o  in  1  cipher config shift-out bit.
- tx_en, tx_p  out  1  cipher TX lane enable and plaintext bit.
- tx_e  in  1  cipher TX ciphertext bit.
- rx_en, rx_e  out  1  cipher RX lane enable and ciphertext bit.
- rx_p  in  1  cipher RX plaintext bit.

## Operation
- FSM states: IDLE, CFG, SHIFT, DRAIN, DONE.
- Reset values: state IDLE, key_loaded 0. All outputs 0, including key_echo, out_data, cfg_*, tx_*, rx_*, and the rr pointer (which is 0 = TX first).
- Ready signals:
  - key_ready = (state==IDLE).
  - tx_ready = (state==IDLE) & key_loaded & ~key_valid & grant_tx.
  - rx_ready is symmetric, using grant_rx.
- Priority in IDLE: a pending key load beats data.
- Data arbitration uses round-robin: if only one lane is valid it is granted. If both are valid, the lane indicated by rr is granted, and rr flips to the other lane after each grant.
- CFG runs M cycles. cfg_en=1 and cfg_i=key_data MSB first (captured copy). cfg_o is shifted into key_echo MSB first over the same cycles. On exit, key_loaded is set and the FSM returns to IDLE.
- SHIFT runs W cycles. Only the granted lane's enable (tx_en or rx_en) is high. The lane bit is taken LSB first from the captured byte. The other lane's enable and bit are held at 0.
- DRAIN holds the lane enable low for LAT cycles. The cipher output bit for input bit k is sampled LAT cycles after it was presented and shifted into the result LSB first.
- DONE lasts 1 cycle: the lane's out_valid=1 and out_data=result. The next state is IDLE.
- Key change mid-stream is impossible: key_ready is low outside IDLE.
- Output data registers hold their value until the next DONE on that lane.

## Timing
- Key load: handshake at cycle 0; cfg_en high on cycles 1..M; key_loaded=1 and key_ready=1 at cycle M+1.
- Data with LAT=1: handshake at cycle 0; lane enable high on cycles 1..W; output bits sampled on cycles 2..W+1; out_valid at cycle W+1+LAT+... = cycle W+2 (DONE); ready again at cycle W+3.
- Data throughput is one word per W+3 cycles (for LAT=1). There are no back-to-back grants.
- Simultaneous tx_valid, rx_valid and key_valid in IDLE: key is granted first, then the data lanes alternate per rr.
- rst asserted in any state: next cycle is IDLE, key_loaded=0, and any in-flight word is discarded with no out_valid.
- Data requests before any key load are held off: ready stays 0 indefinitely and no error is flagged.

## Structure
- Package xor_cipher_pkg holds:
  - the state enum;
  - default M, W and LAT;
  - the lane select type (LANE_TX=0, LANE_RX=1).
- Sub-module xor_cipher_ser serializes a W-bit word LSB first and deserializes a W-bit word LSB first. One shared instance is used because only one lane is active at a time.
- Arbiter, FSM and key shift register live in the top controller.

## Test plan
- Reset, then tx_valid=1 with no key: tx_ready stays 0 for 50 cycles; all cipher outputs stay 0.
- Load key 0xA5A5_0F0F: cfg_en high exactly 32 cycles with cfg_i = MSB-first bits of the key. key_loaded=1 at cycle 33. Load 0x1234_5678 next: key_echo = 0xA5A5_0F0F.
- With a cipher model, TX 0x3C: tx_en high 8 cycles, tx_p = 0,0,1,1,1,1,0,0. tx_out_valid is a single pulse at cycle 10 with model-predicted ciphertext. Feeding that value to RX returns rx_out_data=0x3C.
- tx_valid and rx_valid held continuously: grants alternate TX, RX, TX, RX. Each is separated by W+3 cycles.
- key_valid, tx_valid and rx_valid rise together in IDLE: key is loaded first, then TX then RX.
- Assert rst at cycle 4 of SHIFT: no out_valid. Next cycle all outputs are 0, key_loaded=0 and tx_ready=0.
